// File: rtl/muldiv_pkg.sv
// Shared definitions for the multiply/divide unit: ALU control codes for the
// M-extension operations, FSM state encoding, default datapath width and
// small helpers used at operation accept.
package muldiv_pkg;

  localparam int unsigned WIDTH_DEFAULT = 32;
  localparam int unsigned OP_W          = 5;

  // ALU control codes handled by the multiply/divide unit
  localparam logic [OP_W-1:0] OP_MUL    = 5'b01011;
  localparam logic [OP_W-1:0] OP_MULH   = 5'b01100;
  localparam logic [OP_W-1:0] OP_MULHSU = 5'b01101;
  localparam logic [OP_W-1:0] OP_MULHU  = 5'b01110;
  localparam logic [OP_W-1:0] OP_DIV    = 5'b01111;
  localparam logic [OP_W-1:0] OP_DIVU   = 5'b10000;
  localparam logic [OP_W-1:0] OP_REM    = 5'b10001;
  localparam logic [OP_W-1:0] OP_REMU   = 5'b10010;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_FIX,
    ST_DONE
  } state_t;

  // True for any control code this unit implements
  function automatic logic is_muldiv(input logic [OP_W-1:0] op);
    return (op >= OP_MUL) && (op <= OP_REMU);
  endfunction

  // Unsigned magnitude of a value; the 33-bit intermediate keeps |0x80000000|
  function automatic logic [WIDTH_DEFAULT-1:0] magnitude(input logic [WIDTH_DEFAULT-1:0] x,
                                                          input logic neg);
    logic [WIDTH_DEFAULT:0] ext;
    ext = {neg, x};
    return neg ? WIDTH_DEFAULT'(-ext) : x;
  endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step.
// Ports:
//   rem          - current partial remainder (always < divisor)
//   divisor      - divisor magnitude
//   dividend_bit - next dividend bit shifted into the remainder
//   rem_next_c   - updated partial remainder
//   q_bit_c      - quotient bit produced by this step
module div_step
  import muldiv_pkg::*;
#(
  parameter int unsigned W = WIDTH_DEFAULT
) (
  input  logic [W-1:0] rem,
  input  logic [W-1:0] divisor,
  input  logic         dividend_bit,
  output logic [W-1:0] rem_next_c,
  output logic         q_bit_c
);

  logic [W:0] shifted;
  logic [W:0] trial;

  // Trial subtract; the top bit of the 33-bit difference is the borrow
  always_comb begin
    shifted    = {rem, dividend_bit};
    trial      = shifted - {1'b0, divisor};
    q_bit_c    = ~trial[W];
    rem_next_c = q_bit_c ? trial[W-1:0] : shifted[W-1:0];
  end

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle M-extension multiply/divide unit beside the execute-stage ALU.
// Ports:
//   clk, rst          - clock, asynchronous active-high reset
//   in_valid/in_ready - operation handshake (op, a, b)
//   op                - 5-bit ALU control code (01011..10010)
//   a, b              - operands rs1, rs2
//   out_valid/out_ready - result handshake
//   result            - operation result, held stable in DONE
//   busy              - unit is in any state other than IDLE
// Build option: define MULDIV_FAST_MUL_EN to replace the shift-add multiply
// with a single-cycle combinational multiply at accept.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             busy
);

  localparam int unsigned      W    = WIDTH;
  localparam int unsigned      CW   = $clog2(WIDTH);
  localparam logic [CW-1:0]    LAST = CW'(WIDTH - 1);
  localparam logic [W-1:0]     SMIN = {1'b1, {(W-1){1'b0}}};

  state_t          state;
  logic [OP_W-1:0] op_q;
  logic            sa_q;
  logic            sb_q;
  logic            special;
  logic [CW-1:0]   count;
  logic [2*W-1:0]  acc;      // product {hi,lo} or {remainder, quotient}
  logic [W-1:0]    opnd;     // multiplicand or divisor magnitude

  logic            sa_c;
  logic            sb_c;
  logic [W-1:0]    mag_a;
  logic [W-1:0]    mag_b;
  logic            is_div_c;
  logic            is_quot_c;

  // Signed interpretation of the incoming operands
  always_comb begin
    sa_c = 1'b0;
    sb_c = 1'b0;
    case (op)
      OP_MUL, OP_MULH, OP_DIV, OP_REM: begin
        sa_c = a[W-1];
        sb_c = b[W-1];
      end
      OP_MULHSU: sa_c = a[W-1];
      default: ;
    endcase
    mag_a     = magnitude(a, sa_c);
    mag_b     = magnitude(b, sb_c);
    is_div_c  = op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    is_quot_c = op inside {OP_DIV, OP_DIVU};
  end

`ifdef MULDIV_FAST_MUL_EN
  logic [2*W-1:0] ea_c;
  logic [2*W-1:0] eb_c;
  logic [2*W-1:0] prod_c;

  // Sign-extended operands; the low 2W bits of the product are exact
  always_comb begin
    ea_c   = {{W{sa_c}}, a};
    eb_c   = {{W{sb_c}}, b};
    prod_c = ea_c * eb_c;
  end
`else
  logic [W:0] mul_sum_c;

  // Shift-add step: conditionally add multiplicand into the high half
  always_comb begin
    mul_sum_c = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, opnd} : {(W+1){1'b0}});
  end
`endif

  logic [W-1:0] rem_next_c;
  logic         q_bit_c;

  div_step #(.W(W)) u_div_step (
    .rem          (acc[2*W-1:W]),
    .divisor      (opnd),
    .dividend_bit (acc[W-1]),
    .rem_next_c   (rem_next_c),
    .q_bit_c      (q_bit_c)
  );

  logic [2*W-1:0] prod_fix_c;
  logic [W-1:0]   quo_fix_c;
  logic [W-1:0]   rem_fix_c;

  // Sign correction of the unsigned iteration results
  always_comb begin
`ifdef MULDIV_FAST_MUL_EN
    prod_fix_c = acc;
`else
    prod_fix_c = (sa_q ^ sb_q) ? -acc : acc;
`endif
    quo_fix_c  = (sa_q ^ sb_q) ? -acc[W-1:0] : acc[W-1:0];
    rem_fix_c  = sa_q ? -acc[2*W-1:W] : acc[2*W-1:W];
  end

  // Control FSM and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      result    <= '0;
      count     <= '0;
      op_q      <= '0;
      sa_q      <= 1'b0;
      sb_q      <= 1'b0;
      special   <= 1'b0;
      acc       <= '0;
      opnd      <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            op_q     <= op;
            sa_q     <= sa_c;
            sb_q     <= sb_c;
            count    <= '0;
            special  <= 1'b0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            if (!is_muldiv(op)) begin
              result  <= '0;
              special <= 1'b1;
              state   <= ST_FIX;
            end else if (is_div_c && (b == '0)) begin
              result  <= is_quot_c ? '1 : a;
              special <= 1'b1;
              state   <= ST_FIX;
            end else if ((op == OP_DIV || op == OP_REM) && a == SMIN && b == '1) begin
              result  <= (op == OP_DIV) ? SMIN : '0;
              special <= 1'b1;
              state   <= ST_FIX;
            end else if (is_div_c) begin
              acc   <= {{W{1'b0}}, mag_a};
              opnd  <= mag_b;
              state <= ST_DIV;
            end else begin
`ifdef MULDIV_FAST_MUL_EN
              acc   <= prod_c;
              state <= ST_FIX;
`else
              acc   <= {{W{1'b0}}, mag_b};
              opnd  <= mag_a;
              state <= ST_MUL;
`endif
            end
          end
        end
`ifndef MULDIV_FAST_MUL_EN
        ST_MUL: begin
          acc   <= {mul_sum_c, acc[W-1:1]};
          count <= count + CW'(1);
          if (count == LAST) state <= ST_FIX;
        end
`endif
        ST_DIV: begin
          acc   <= {rem_next_c, acc[W-2:0], q_bit_c};
          count <= count + CW'(1);
          if (count == LAST) state <= ST_FIX;
        end
        ST_FIX: begin
          if (!special) begin
            case (op_q)
              OP_MUL:                       result <= prod_fix_c[W-1:0];
              OP_MULH, OP_MULHSU, OP_MULHU: result <= prod_fix_c[2*W-1:W];
              OP_DIV, OP_DIVU:              result <= quo_fix_c;
              OP_REM, OP_REMU:              result <= rem_fix_c;
              default:                      result <= '0;
            endcase
          end
          out_valid <= 1'b1;
          state     <= ST_DONE;
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: begin
          state     <= ST_IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: table of directed operations with
// expected result and accept-to-out_valid latency, plus backpressure and
// mid-operation reset sequences.
module tb_muldiv_unit;

  localparam logic [4:0] C_MUL    = 5'b01011;
  localparam logic [4:0] C_MULH   = 5'b01100;
  localparam logic [4:0] C_MULHSU = 5'b01101;
  localparam logic [4:0] C_MULHU  = 5'b01110;
  localparam logic [4:0] C_DIV    = 5'b01111;
  localparam logic [4:0] C_DIVU   = 5'b10000;
  localparam logic [4:0] C_REM    = 5'b10001;
  localparam logic [4:0] C_REMU   = 5'b10010;

`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif
  localparam int DIV_LAT = 33;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        busy;

  int checks = 0;
  int errors = 0;

  muldiv_unit dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Issue one operation, measure latency, check result and return to idle
  task automatic run_op(input string name, input logic [4:0] o, input logic [31:0] x,
                        input logic [31:0] y, input logic [31:0] exp, input int exp_lat);
    int k;
    @(negedge clk);
    k = 0;
    while (!in_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL %s_accept: in_ready never rose", name);
      return;
    end
    op = o; a = x; b = y; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    k = 0;
    while (!out_valid && k < 100) begin
      @(posedge clk);
      @(negedge clk);
      k++;
    end
    check_int({name, "_lat"}, k, exp_lat);
    check32({name, "_res"}, result, exp);
    if (out_valid) begin
      @(posedge clk);
      @(negedge clk);
      check32({name, "_idle"}, {30'd0, in_ready, out_valid}, 32'h2);
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; op = '0; a = '0; b = '0; out_ready = 1'b1;

    vecs.push_back('{"mul_7_m3",      C_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, MUL_LAT});
    vecs.push_back('{"mul_m1_m1",     C_MUL,    32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, MUL_LAT});
    vecs.push_back('{"mulhu_m1",      C_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, MUL_LAT});
    vecs.push_back('{"mulh_m1",       C_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, MUL_LAT});
    vecs.push_back('{"mulhsu_m1",     C_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, MUL_LAT});
    vecs.push_back('{"mulh_min",      C_MULH,   32'h80000000, 32'h80000000, 32'h40000000, MUL_LAT});
    vecs.push_back('{"mulhsu_min",    C_MULHSU, 32'h80000000, 32'h80000000, 32'hC0000000, MUL_LAT});
    vecs.push_back('{"div_m7_2",      C_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, DIV_LAT});
    vecs.push_back('{"rem_m7_2",      C_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, DIV_LAT});
    vecs.push_back('{"div_7_m2",      C_DIV,    32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, DIV_LAT});
    vecs.push_back('{"rem_7_m2",      C_REM,    32'd7,        32'hFFFFFFFE, 32'h00000001, DIV_LAT});
    vecs.push_back('{"divu_100_7",    C_DIVU,   32'd100,      32'd7,        32'd14,       DIV_LAT});
    vecs.push_back('{"remu_100_7",    C_REMU,   32'd100,      32'd7,        32'd2,        DIV_LAT});
    vecs.push_back('{"divu_max_1",    C_DIVU,   32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, DIV_LAT});
    vecs.push_back('{"div_5_0",       C_DIV,    32'd5,        32'd0,        32'hFFFFFFFF, 1});
    vecs.push_back('{"rem_5_0",       C_REM,    32'd5,        32'd0,        32'd5,        1});
    vecs.push_back('{"divu_5_0",      C_DIVU,   32'd5,        32'd0,        32'hFFFFFFFF, 1});
    vecs.push_back('{"remu_5_0",      C_REMU,   32'd5,        32'd0,        32'd5,        1});
    vecs.push_back('{"div_ovf",       C_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1});
    vecs.push_back('{"rem_ovf",       C_REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1});
    vecs.push_back('{"bad_op",        5'b00000, 32'd3,        32'd4,        32'h00000000, 1});

    // Reset state
    #1;
    check32("reset_ctrl", {29'd0, in_ready, out_valid, busy}, 32'h4);
    check32("reset_result", result, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i])
      run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);

    // Backpressure: DONE held with out_ready low, new requests ignored
    begin
      int k;
      @(negedge clk);
      out_ready = 1'b0;
      op = C_DIVU; a = 32'd100; b = 32'd7; in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      k = 0;
      while (!out_valid && k < 100) begin
        @(posedge clk);
        @(negedge clk);
        k++;
      end
      check_int("bp_lat", k, DIV_LAT);
      op = C_MUL; a = 32'd2; b = 32'd3; in_valid = 1'b1;
      for (int c = 0; c < 10; c++) begin
        @(negedge clk);
        check32("bp_ctrl", {30'd0, out_valid, in_ready}, 32'h2);
        check32("bp_result", result, 32'd14);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check32("bp_release", {30'd0, in_ready, out_valid}, 32'h2);
      repeat (2) @(negedge clk);
      check32("bp_no_ghost", {30'd0, busy, out_valid}, 32'h0);
    end

    // Reset in the middle of a division
    @(negedge clk);
    op = C_DIV; a = 32'd1000; b = 32'd3; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (15) @(posedge clk);
    #2;
    check32("pre_rst_busy", {31'd0, busy}, 32'h1);
    rst = 1'b1;
    #1;
    check32("async_rst_ctrl", {29'd0, in_ready, out_valid, busy}, 32'h4);
    check32("async_rst_result", result, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    run_op("post_rst_divu", C_DIVU, 32'd9, 32'd3, 32'd3, DIV_LAT);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
